// File: rtl/hack_rom_loader_if.sv
// Byte-stream handshake and instruction-memory write bus between a byte source and the ROM loader.
interface hack_rom_loader_if #(
    parameter int ADDR_W = 15
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, rom_we, rom_addr, rom_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, rom_we, rom_addr, rom_wdata
    );
endinterface

// File: rtl/hack_rom_loader.sv
// Boot loader: assembles a big-endian length-prefixed byte stream into 16-bit words,
// writes them to instruction memory and holds the HACK CPU in reset until the program is resident.
module hack_rom_loader #(
    parameter int ADDR_W = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_req,
    hack_rom_loader_if.slave   bus,
    output logic               cpu_reset,
    output logic               loading,
    output logic               done,
    output logic               error,
    output logic [15:0]        words_loaded
);

    typedef enum logic [2:0] {
        LEN_HI, LEN_LO, DATA_HI, DATA_LO, FLUSH, RUN, ERROR
    } state_t;

    localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;

    state_t            state, state_n;
    logic [7:0]        len_hi;
    logic [7:0]        data_hi;
    logic [15:0]       len;
    logic [15:0]       len_cand;
    logic [ADDR_W-1:0] index;
    logic              accept;
    logic              last_word;

    assign bus.rx_ready = !load_req && (state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO});
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign len_cand     = {len_hi, bus.rx_data};
    assign last_word    = (17'(index) + 17'd1) == 17'(len);

    // NOTE: combinational blocks assign a default first so no path leaves state_n unassigned (no latch).
    always_comb begin
        state_n = state;
        if (load_req) begin
            state_n = LEN_HI;
        end else begin
            case (state)
                LEN_HI:  if (accept) state_n = LEN_LO;
                LEN_LO:  if (accept) state_n = (len_cand == 16'd0 || 17'(len_cand) > MAX_N) ? ERROR : DATA_HI;
                DATA_HI: if (accept) state_n = DATA_LO;
                DATA_LO: if (accept) state_n = last_word ? FLUSH : DATA_HI;
                FLUSH:   state_n = RUN;
                default: state_n = state;
            endcase
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= LEN_HI;
            len_hi        <= '0;
            data_hi       <= '0;
            len           <= '0;
            index         <= '0;
            bus.rom_we    <= 1'b0;
            bus.rom_addr  <= '0;
            bus.rom_wdata <= '0;
            words_loaded  <= '0;
            cpu_reset     <= 1'b1;
            loading       <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state      <= state_n;
            bus.rom_we <= 1'b0;
            // Release waits for one settled cycle in RUN, so the last write retires before the CPU fetches.
            cpu_reset  <= !(state == RUN && state_n == RUN);
            done       <= (state == RUN && state_n == RUN);
            error      <= (state_n == ERROR);
            loading    <= !(state_n inside {RUN, ERROR});

            if (load_req) begin
                words_loaded <= '0;
                index        <= '0;
            end else if (accept) begin
                case (state)
                    LEN_HI:  len_hi <= bus.rx_data;
                    LEN_LO: begin
                        len          <= len_cand;
                        index        <= '0;
                        words_loaded <= '0;
                    end
                    DATA_HI: data_hi <= bus.rx_data;
                    DATA_LO: begin
                        bus.rom_we    <= 1'b1;
                        bus.rom_wdata <= {data_hi, bus.rx_data};
                        bus.rom_addr  <= index;
                        if (17'(words_loaded) < MAX_N)
                            words_loaded <= words_loaded + 16'd1;
                        if (!last_word)
                            index <= index + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Scoreboard bench for hack_rom_loader with a 4-bit address so the maximum-length case is short.
module tb_hack_rom_loader;

    localparam int AW = 4;

    logic        clk;
    logic        reset;
    logic        load_req;
    logic        cpu_reset;
    logic        loading;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    hack_rom_loader_if #(.ADDR_W(AW)) bus ();

    hack_rom_loader #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .bus          (bus.slave),
        .cpu_reset    (cpu_reset),
        .loading      (loading),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  vectors;
    int  miscompares;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && bus.rom_we) begin
            vectors++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write got addr=%h data=%h required none", bus.rom_addr, bus.rom_wdata);
                miscompares++;
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.rom_addr, bus.rom_wdata} !== mon_e) begin
                    $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                             bus.rom_addr, bus.rom_wdata, mon_e.addr, mon_e.data);
                    miscompares++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 0;
        bus.rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rx_ready === 1'b1) begin
                got = 1;
                break;
            end
        end
        vectors++;
        if (!got) begin
            $display("FAIL byte_accept got rx_ready=%b required 1 within 50 cycles", bus.rx_ready);
            miscompares++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [15:0] d, input bit gaps);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        send_byte(d[15:8], gaps ? int'($urandom_range(0, 5)) : 0);
        send_byte(d[7:0],  gaps ? int'($urandom_range(0, 5)) : 0);
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic wait_run(input string name);
        bit got = 0;
        bus.rx_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1;
                break;
            end
        end
        vectors++;
        if (!got || cpu_reset !== 1'b0) begin
            $display("FAIL %s_run got done=%b cpu_reset=%b required done=1 cpu_reset=0", name, done, cpu_reset);
            miscompares++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_writes got %0d pending required 0", name, exp_q.size());
            miscompares++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        load_req     = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if ({cpu_reset, bus.rom_we, bus.rom_addr, bus.rom_wdata, words_loaded, error, done, loading, bus.rx_ready}
            !== {1'b1, 1'b0, {AW{1'b0}}, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            $display("FAIL reset_values got cr=%b we=%b a=%h d=%h wl=%h e=%b dn=%b ld=%b rdy=%b required 1 0 0 0000 0000 0 0 1 1",
                     cpu_reset, bus.rom_we, bus.rom_addr, bus.rom_wdata, words_loaded, error, done, loading, bus.rx_ready);
            miscompares++;
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (cpu_reset !== 1'b1 || loading !== 1'b1) begin
            $display("FAIL reset_release got cpu_reset=%b loading=%b required 1 1", cpu_reset, loading);
            miscompares++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_program_load();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(4'h0, 16'h1234, 0);
        send_word(4'h1, 16'hABCD, 0);
        send_word(4'h2, 16'h8000, 0);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.rom_we !== 1'b1 || cpu_reset !== 1'b1) begin
            $display("FAIL latency_k got rom_we=%b cpu_reset=%b required 1 1", bus.rom_we, cpu_reset);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (bus.rom_we !== 1'b0 || cpu_reset !== 1'b1) begin
            $display("FAIL latency_k1 got rom_we=%b cpu_reset=%b required 0 1", bus.rom_we, cpu_reset);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (cpu_reset !== 1'b0 || done !== 1'b1 || words_loaded !== 16'd3) begin
            $display("FAIL latency_k2 got cpu_reset=%b done=%b words=%0d required 0 1 3", cpu_reset, done, words_loaded);
            miscompares++;
        end
        vectors++;
        if (bus.rom_addr !== 4'h2 || bus.rom_wdata !== 16'h8000) begin
            $display("FAIL write_hold got addr=%h data=%h required 2 8000", bus.rom_addr, bus.rom_wdata);
            miscompares++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_gaps();
        logic [15:0] data[3] = '{16'h1234, 16'hABCD, 16'h8000};
        pulse_load_req();
        send_byte(8'h00, int'($urandom_range(0, 5)));
        send_byte(8'h03, int'($urandom_range(0, 5)));
        for (int i = 0; i < 3; i++) begin
            send_word(AW'(i), data[i], 1);
            vectors++;
            if (cpu_reset !== 1'b1 || done !== 1'b0) begin
                $display("FAIL gaps_hold word=%0d got cpu_reset=%b done=%b required 1 0", i, cpu_reset, done);
                miscompares++;
            end
        end
        wait_run("gaps");
        vectors++;
        if (words_loaded !== 16'd3) begin
            $display("FAIL gaps_count got %0d required 3", words_loaded);
            miscompares++;
        end
    endtask

    task automatic test_zero_length();
        pulse_load_req();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        bus.rx_data = 8'h5A;
        repeat (3) @(negedge clk);
        vectors++;
        if ({error, bus.rx_ready, cpu_reset, loading, done} !== 5'b10100) begin
            $display("FAIL zero_len_error got e=%b rdy=%b cr=%b ld=%b dn=%b required 1 0 1 0 0",
                     error, bus.rx_ready, cpu_reset, loading, done);
            miscompares++;
        end
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        pulse_load_req();
        @(negedge clk);
        vectors++;
        if (error !== 1'b0 || bus.rx_ready !== 1'b1 || loading !== 1'b1) begin
            $display("FAIL zero_len_restart got e=%b rdy=%b ld=%b required 0 1 1", error, bus.rx_ready, loading);
            miscompares++;
        end
        @(posedge clk);
        #1;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(4'h0, 16'h7788, 0);
        wait_run("zero_len_reload");
    endtask

    task automatic test_overlength();
        pulse_load_req();
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (error !== 1'b1 || cpu_reset !== 1'b1 || bus.rx_ready !== 1'b0) begin
            $display("FAIL overlength got e=%b cr=%b rdy=%b required 1 1 0", error, cpu_reset, bus.rx_ready);
            miscompares++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_max_length();
        pulse_load_req();
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        for (int i = 0; i < 16; i++)
            send_word(AW'(i), 16'hC000 + 16'(i), 0);
        wait_run("max_len");
        vectors++;
        if (words_loaded !== 16'd16 || error !== 1'b0 || bus.rom_addr !== 4'hF) begin
            $display("FAIL max_len_final got words=%0d e=%b addr=%h required 16 0 f", words_loaded, error, bus.rom_addr);
            miscompares++;
        end
    endtask

    task automatic test_load_req_mid();
        pulse_load_req();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(4'h0, 16'h1234, 0);
        vectors++;
        if (words_loaded !== 16'd1) begin
            $display("FAIL mid_before got words=%0d required 1", words_loaded);
            miscompares++;
        end
        bus.rx_data  = 8'hAB;
        bus.rx_valid = 1'b1;
        load_req     = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.rx_ready !== 1'b0) begin
            $display("FAIL mid_ready got rx_ready=%b required 0", bus.rx_ready);
            miscompares++;
        end
        @(posedge clk);
        #1;
        load_req     = 1'b0;
        bus.rx_valid = 1'b0;
        vectors++;
        if (words_loaded !== 16'd0 || cpu_reset !== 1'b1 || loading !== 1'b1 || bus.rom_we !== 1'b0) begin
            $display("FAIL mid_restart got words=%0d cr=%b ld=%b we=%b required 0 1 1 0",
                     words_loaded, cpu_reset, loading, bus.rom_we);
            miscompares++;
        end
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(4'h0, 16'h55AA, 0);
        wait_run("mid_reload");
    endtask

    task automatic test_async_reset();
        pulse_load_req();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(4'h0, 16'h1111, 0);
        send_byte(8'h22, 0);
        bus.rx_valid = 1'b0;
        vectors++;
        if (words_loaded !== 16'd1) begin
            $display("FAIL async_before got words=%0d required 1", words_loaded);
            miscompares++;
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (cpu_reset !== 1'b1 || bus.rom_we !== 1'b0 || words_loaded !== 16'd0 || loading !== 1'b1) begin
            $display("FAIL async_reset got cr=%b we=%b words=%0d ld=%b required 1 0 0 1",
                     cpu_reset, bus.rom_we, words_loaded, loading);
            miscompares++;
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(4'h0, 16'hA55A, 0);
        send_word(4'h1, 16'h0FF0, 0);
        wait_run("async_reload");
        vectors++;
        if (words_loaded !== 16'd2) begin
            $display("FAIL async_count got %0d required 2", words_loaded);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_program_load();
        test_gaps();
        test_zero_length();
        test_overlength();
        test_max_length();
        test_load_req_mid();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
